imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the core's immediate extender: packs a signed 32-bit immediate into the I/S/B/J field positions of a 32-bit RV32I instruction word.
- Fields supplied by a template word (opcode/rd/rs1/rs2/funct) are preserved.
- Sits between the test program generator / boot loader and instruction memory.
- Valid/ready handshake on input and output, DEPTH-entry output buffer, range/alignment checking, statistics counters.

Parameters:
- DEPTH, 2, output buffer entries (power of two, >=2)
- CNT_W, 16, width of instr_cnt and err_cnt

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- imm_src  in  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- imm32  in  32  signed immediate (byte offset for B/J)
- base_instr  in  32  template word; immediate bit positions are overwritten
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_err  out  2  bit0 range error, bit1 misalignment error; travels with out_instr
- instr_cnt  out  CNT_W  words accepted since reset; wraps
- err_cnt  out  CNT_W  accepted words with out_err!=0; saturates at all-ones

Behaviour:
- Reset (async assert, sync release): buffer empty, out_valid=0, out_instr=0, out_err=0, instr_cnt=0, err_cnt=0. in_ready=1 during the first cycle after release.
- Accept: in_valid&&in_ready at rising edge.
  - Encode combinationally.
  - Push {word, err} into the buffer.
  - instr_cnt += 1; err_cnt += 1 if err!=0.
- Field placement (all bits not listed are copied from base_instr):
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0]
  - B: [31]=imm[12]; [7]=imm[11]; [30:25]=imm[10:5]; [11:8]=imm[4:1]
  - J: [31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12]
- Range check (bit0 set if violated):
  - I/S: imm32[31:11] all equal
  - B: imm32[31:12] all equal
  - J: imm32[31:20] all equal
- Alignment check (bit1): B/J with imm32[0]=1. Always 0 for I/S.
- Errored words are still encoded (truncated fields) and emitted; they are never dropped.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 when the buffer was empty. Order is strict FIFO.
- Output: out_valid=!empty. out_instr/out_err show the head entry and are held stable while out_valid&&!out_ready. Pop on out_valid&&out_ready.
- in_ready = (count<DEPTH), registered state only. No combinational path from out_ready to in_ready. When full, a simultaneous pop does not enable a push that cycle.
- Simultaneous push and pop when not full or empty: count unchanged; both take effect.
- Empty: out_instr/out_err hold their last popped value (0 after reset). Consumers must qualify with out_valid.
- Pointers wrap modulo DEPTH.
- Counter overflow: instr_cnt wraps from all-ones to 0; err_cnt sticks at all-ones.
- rst mid-operation: buffered words are discarded immediately and counters clear. No partial word is ever emitted.
- Correctness property: for every out_err==0 word, extending out_instr with the same imm_src yields imm32.

Decomposition:
- Package imm_pkg:
  - imm_src_t enum (IMM_I=2'b00, IMM_S, IMM_B, IMM_J), shared with the extender and control decoder
  - ERR_RANGE/ERR_ALIGN bit constants
  - pure function encode_imm(imm_src_t, base, imm) returning word and err
- One sub-module: imm_enc_fifo, a parameterised synchronous FIFO (data width 34, DEPTH) with full/empty/count.
- The top module holds the encode function call and the counters.

Test Plan:
- I-type: base=0x00000013, imm=-1 (0xFFFFFFFF), out_ready=1. Expect out_instr=0xFFF00013 and out_err=0 one cycle after accept; instr_cnt=1.
- B-type: base=0x00000063, imm=0xFFFFF000 (-4096). Expect out_instr=0x80000063, out_err=0. imm=4096 gives out_err=01. imm=6 gives out_err=00; imm=7 gives out_err=10. err_cnt=2 after these four words.
- J-type: base=0x0000006F, imm=0x000FFFFE. Expect out_instr=0x7FFFF06F, out_err=0. Then imm=0x00100000 gives out_err=01.
- Backpressure: out_ready=0, push 3 S-type words.
  - in_ready drops after 2 accepts.
  - out_instr stays stable.
  - Raise out_ready: words emerge in order; in_ready returns 1 the cycle after the first pop.
- Reset mid-stream: buffer full, assert rst asynchronously between edges. Expect out_valid=0 and counters=0 immediately; after release, a new I-type word emits normally.
- Random round-trip: 10k random imm_src/imm32 with random out_ready. Every out_err==0 word, extended by the extender model, equals its imm32. err_cnt matches the scoreboard.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate types and the I/S/B/J immediate packer.
// Used by the encoder, the extender and the control decoder.
package imm_pkg;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

   localparam int ERR_RANGE = 0;
   localparam int ERR_ALIGN = 1;

   typedef struct packed {
      logic [31:0] word;
      logic [1:0]  err;
   } enc_t;

   function automatic enc_t encode_imm(
      input imm_src_t    src,
      input logic [31:0] base,
      input logic [31:0] imm
   );
      enc_t r;
      r.word = base;
      r.err  = 2'b00;
      unique case (src)
         IMM_I: begin
            r.word[31:20] = imm[11:0];
            r.err[ERR_RANGE] = !(&imm[31:11] || !(|imm[31:11]));
         end
         IMM_S: begin
            r.word[31:25] = imm[11:5];
            r.word[11:7]  = imm[4:0];
            r.err[ERR_RANGE] = !(&imm[31:11] || !(|imm[31:11]));
         end
         IMM_B: begin
            r.word[31]    = imm[12];
            r.word[7]     = imm[11];
            r.word[30:25] = imm[10:5];
            r.word[11:8]  = imm[4:1];
            r.err[ERR_RANGE] = !(&imm[31:12] || !(|imm[31:12]));
            r.err[ERR_ALIGN] = imm[0];
         end
         IMM_J: begin
            r.word[31]    = imm[20];
            r.word[30:21] = imm[10:1];
            r.word[20]    = imm[11];
            r.word[19:12] = imm[19:12];
            r.err[ERR_RANGE] = !(&imm[31:20] || !(|imm[31:20]));
            r.err[ERR_ALIGN] = imm[0];
         end
         default: r.err = 2'b00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/imm_enc_fifo.sv
// Small synchronous FIFO; when empty the read port keeps
// showing the last popped entry (zero after reset).
module imm_enc_fifo
   import imm_pkg::*;
#(
   parameter int W     = 34,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  hold;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? hold : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         hold   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            hold   <= mem[rd_ptr];
         end
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/imm_encoder.sv
// Packs a signed immediate into an RV32I template word, buffers
// the result with its error flags and keeps accept/error counts.
module imm_encoder
   import imm_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       imm_src,
   input  logic [31:0]      imm32,
   input  logic [31:0]      base_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [1:0]       out_err,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int AW = $clog2(DEPTH);

   enc_t        enc;
   enc_t        head;
   logic        push;
   logic        pop;
   logic        empty;
   logic [AW:0] level;

   assign enc  = encode_imm(imm_src_t'(imm_src), base_instr, imm32);

   // in_ready comes only from registered occupancy
   assign in_ready  = (level < (AW+1)'(DEPTH));
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign out_instr = head.word;
   assign out_err   = head.err;

   imm_enc_fifo #(
      .W     (34),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (enc),
      .pop   (pop),
      .rdata (head),
      .empty (empty),
      .count (level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_cnt <= '0;
         err_cnt   <= '0;
      end else if (push) begin
         instr_cnt <= instr_cnt + 1'b1;
         if ((|enc.err) && !(&err_cnt))
            err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized checks of imm_encoder against an
// immediate-extender reference model.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  imm_src = 2'b00;
   logic [31:0] imm32 = '0;
   logic [31:0] base_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [1:0]  out_err;
   logic [15:0] instr_cnt;
   logic [15:0] err_cnt;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] base;
   } req_t;

   req_t sb[$];

   imm_encoder #(.DEPTH(2), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imm_src    (imm_src),
      .imm32      (imm32),
      .base_instr (base_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_err    (out_err),
      .instr_cnt  (instr_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] extend(input logic [1:0] s,
                                          input logic [31:0] w);
      case (s)
         2'd0: return {{20{w[31]}}, w[31:20]};
         2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
         2'd2: return {{19{w[31]}}, w[31], w[7], w[30:25],
                       w[11:8], 1'b0};
         default: return {{11{w[31]}}, w[31], w[19:12], w[20],
                          w[30:21], 1'b0};
      endcase
   endfunction

   function automatic logic [31:0] imm_mask(input logic [1:0] s);
      case (s)
         2'd0: return 32'hFFF0_0000;
         2'd1: return 32'hFE00_0F80;
         2'd2: return 32'hFE00_0F80;
         default: return 32'hFFFF_F000;
      endcase
   endfunction

   function automatic int field_bits(input logic [1:0] s);
      case (s)
         2'd0, 2'd1: return 12;
         2'd2: return 13;
         default: return 21;
      endcase
   endfunction

   function automatic logic [1:0] model_err(input logic [1:0] s,
                                            input logic [31:0] imm);
      longint v, lim;
      logic [1:0] e;
      v   = longint'($signed(imm));
      lim = longint'(1) << (field_bits(s) - 1);
      e = 2'b00;
      e[0] = (v < -lim) || (v >= lim);
      e[1] = (s >= 2'd2) && (v % 2 != 0);
      return e;
   endfunction

   function automatic logic [31:0] model_ext(input logic [1:0] s,
                                             input logic [31:0] imm);
      longint m, t;
      logic [31:0] r;
      m = longint'(1) << field_bits(s);
      t = longint'(imm) % m;
      if (t >= m / 2) t = t - m;
      if (s >= 2'd2 && (t % 2 != 0)) t = t - 1;
      r = t[31:0];
      return r;
   endfunction

   task automatic reset_dut();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_word(input logic [1:0] s, input logic [31:0] imm,
                            input logic [31:0] base);
      @(negedge clk);
      imm_src = s; imm32 = imm; base_instr = base;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 2'b00 ||
          instr_cnt !== 16'h0 || err_cnt !== 16'h0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset: valid=%b instr=%h err=%b ic=%0d ec=%0d rdy=%b",
                  out_valid, out_instr, out_err, instr_cnt, err_cnt, in_ready);
      end
   endtask

   task automatic test_i_type();
      reset_dut();
      out_ready = 1'b1;
      push_word(2'd0, 32'hFFFF_FFFF, 32'h0000_0013);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'hFFF0_0013 ||
          out_err !== 2'b00 || instr_cnt !== 16'd1) begin
         fails++;
         $display("FAIL i_type: valid=%b instr=%h err=%b ic=%0d want 1 fff00013 00 1",
                  out_valid, out_instr, out_err, instr_cnt);
      end
   endtask

   task automatic test_b_type();
      logic [31:0] imms [4] = '{32'hFFFF_F000, 32'd4096, 32'd6, 32'd7};
      logic [31:0] words [4] = '{32'h8000_0063, 32'h0000_0063,
                                 32'h0000_0363, 32'h0000_0363};
      logic [1:0]  errs [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
      reset_dut();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_word(2'd2, imms[i], 32'h0000_0063);
         checks++;
         if (out_valid !== 1'b1 || out_err !== errs[i] ||
             (i != 1 && out_instr !== words[i])) begin
            fails++;
            $display("FAIL b_type[%0d]: instr=%h err=%b want %h %b",
                     i, out_instr, out_err, words[i], errs[i]);
         end
      end
      checks++;
      if (err_cnt !== 16'd2 || instr_cnt !== 16'd4) begin
         fails++;
         $display("FAIL b_counts: ec=%0d ic=%0d want 2 4", err_cnt, instr_cnt);
      end
   endtask

   task automatic test_j_type();
      reset_dut();
      out_ready = 1'b1;
      push_word(2'd3, 32'h000F_FFFE, 32'h0000_006F);
      checks++;
      if (out_instr !== 32'h7FFF_F06F || out_err !== 2'b00) begin
         fails++;
         $display("FAIL j_type: instr=%h err=%b want 7ffff06f 00",
                  out_instr, out_err);
      end
      push_word(2'd3, 32'h0010_0000, 32'h0000_006F);
      checks++;
      if (out_err !== 2'b01) begin
         fails++;
         $display("FAIL j_range: err=%b want 01", out_err);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w0 = 32'h0000_2823;
      logic [31:0] w1 = 32'hFE00_2E23;
      logic [31:0] w2 = 32'h7E00_2FA3;
      reset_dut();
      push_word(2'd1, 32'h0000_0010, 32'h0000_2023);
      checks++;
      if (in_ready !== 1'b1 || out_instr !== w0) begin
         fails++;
         $display("FAIL bp_first: rdy=%b instr=%h want 1 %h", in_ready, out_instr, w0);
      end
      push_word(2'd1, 32'hFFFF_FFFC, 32'h0000_2023);
      checks++;
      if (in_ready !== 1'b0 || out_instr !== w0) begin
         fails++;
         $display("FAIL bp_full: rdy=%b instr=%h want 0 %h", in_ready, out_instr, w0);
      end
      @(negedge clk);
      imm_src = 2'd1; imm32 = 32'h0000_07FF; base_instr = 32'h0000_2023;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_instr !== w0 || instr_cnt !== 16'd2) begin
         fails++;
         $display("FAIL bp_hold: rdy=%b instr=%h ic=%0d want 0 %h 2",
                  in_ready, out_instr, instr_cnt, w0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_instr !== w1 || instr_cnt !== 16'd2) begin
         fails++;
         $display("FAIL bp_pop1: rdy=%b instr=%h ic=%0d want 1 %h 2",
                  in_ready, out_instr, instr_cnt, w1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_instr !== w2 || instr_cnt !== 16'd3 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL bp_pop2: instr=%h ic=%0d valid=%b want %h 3 1",
                  out_instr, instr_cnt, out_valid, w2);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== w2) begin
         fails++;
         $display("FAIL bp_drain: valid=%b instr=%h want 0 %h", out_valid, out_instr, w2);
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      push_word(2'd0, 32'd1, 32'h0000_0013);
      push_word(2'd0, 32'd2, 32'h0000_0013);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || instr_cnt !== 16'd0 || err_cnt !== 16'd0) begin
         fails++;
         $display("FAIL rst_mid: valid=%b ic=%0d ec=%0d want 0 0 0",
                  out_valid, instr_cnt, err_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      push_word(2'd0, 32'd5, 32'h0000_0013);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h0050_0013 || instr_cnt !== 16'd1) begin
         fails++;
         $display("FAIL rst_after: valid=%b instr=%h ic=%0d want 1 00500013 1",
                  out_valid, out_instr, instr_cnt);
      end
   endtask

   task automatic test_random();
      req_t r;
      logic [1:0] e;
      int n_in = 0;
      int n_err = 0;
      int budget;
      reset_dut();
      sb.delete();
      for (int cyc = 0; cyc < 10000 + 200; cyc++) begin
         @(negedge clk);
         if (cyc < 10000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            imm_src  = 2'($urandom_range(0, 3));
            base_instr = $urandom;
            case ($urandom_range(0, 3))
               0: imm32 = $urandom;
               1: imm32 = 32'($urandom_range(0, 4095)) - 32'd2048;
               2: imm32 = 32'($urandom_range(0, 8191)) - 32'd4096;
               default: imm32 = 32'($urandom_range(0, 2097151)) - 32'd1048576;
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL rnd_extra: instr=%h with empty scoreboard", out_instr);
            end else begin
               r = sb.pop_front();
               e = model_err(r.src, r.imm);
               if (out_err !== e ||
                   extend(r.src, out_instr) !== model_ext(r.src, r.imm) ||
                   (out_instr & ~imm_mask(r.src)) !== (r.base & ~imm_mask(r.src)) ||
                   (e == 2'b00 && extend(r.src, out_instr) !== r.imm)) begin
                  fails++;
                  $display("FAIL rnd_word: src=%0d imm=%h base=%h instr=%h err=%b want err %b ext %h",
                           r.src, r.imm, r.base, out_instr, out_err, e,
                           model_ext(r.src, r.imm));
               end
            end
         end
         if (in_valid && in_ready) begin
            r.src = imm_src; r.imm = imm32; r.base = base_instr;
            sb.push_back(r);
            n_in++;
            if (model_err(imm_src, imm32) != 2'b00) n_err++;
         end
      end
      budget = 0;
      while (out_valid && budget < 10) begin
         @(posedge clk);
         budget++;
      end
      #1;
      checks++;
      if (sb.size() != 0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rnd_drain: %0d words left, valid=%b", sb.size(), out_valid);
      end
      checks++;
      if (err_cnt !== 16'(n_err) || instr_cnt !== 16'(n_in)) begin
         fails++;
         $display("FAIL rnd_counts: ec=%0d ic=%0d want %0d %0d",
                  err_cnt, instr_cnt, n_err, n_in);
      end
   endtask

   initial begin
      test_reset();
      test_i_type();
      test_b_type();
      test_j_type();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
      $finish;
   end

endmodule
